// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a 4-to-1 mux.
// Grants one requester for up to HOLD cycles and registers the data.
module mux4_rr_arbiter #(
  parameter int HOLD  = 2,
  parameter int WIDTH = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] x,
  output logic [1:0]       s,
  output logic [3:0]       gnt,
  output logic [WIDTH-1:0] m,
  output logic             valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(HOLD - 1);

  state_t     state;
  logic [1:0] last;
  logic [3:0] cnt;

  // {found, index} of the first requester after pointer p
  function automatic logic [2:0] pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [2:0]       arb_idle;
  logic [2:0]       arb_rel;
  logic [WIDTH-1:0] sel;
  logic             cur_req;
  logic             release_now;

  always_comb begin
    arb_idle    = pick(req, last);
    arb_rel     = pick(req, s);
    cur_req     = req[s];
    release_now = (cnt == 4'd0) || !cur_req;
  end

  always_comb begin
    sel = u;
    unique case (s)
      2'd0: sel = u;
      2'd1: sel = v;
      2'd2: sel = w;
      2'd3: sel = x;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      s     <= 2'd0;
      gnt   <= 4'b0000;
      m     <= '0;
      valid <= 1'b0;
      last  <= 2'd3;
      cnt   <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          valid <= 1'b0;
          if (arb_idle[2]) begin
            state <= GRANT;
            s     <= arb_idle[1:0];
            gnt   <= 4'b0001 << arb_idle[1:0];
            cnt   <= CNT_LOAD;
          end else begin
            gnt <= 4'b0000;
          end
        end
        GRANT: begin
          valid <= cur_req;
          if (cur_req) m <= sel;
          if (release_now) begin
            last <= s;
            if (arb_rel[2]) begin
              s   <= arb_rel[1:0];
              gnt <= 4'b0001 << arb_rel[1:0];
              cnt <= CNT_LOAD;
            end else begin
              state <= IDLE;
              gnt   <= 4'b0000;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter at HOLD = 2, 4 and 1.
// Directed scenarios then random traffic against a reference model.
module tb_mux4_rr_arbiter;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] req;
  logic [1:0] u, v, w, x;

  logic [1:0] s0, s1, s2;
  logic [3:0] g0, g1, g2;
  logic [1:0] m0, m1, m2;
  logic       v0, v1, v2;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  mux4_rr_arbiter #(.HOLD(2), .WIDTH(2)) dut0 (
    .Clock(Clock), .Reset(Reset), .req(req),
    .u(u), .v(v), .w(w), .x(x),
    .s(s0), .gnt(g0), .m(m0), .valid(v0)
  );

  mux4_rr_arbiter #(.HOLD(4), .WIDTH(2)) dut1 (
    .Clock(Clock), .Reset(Reset), .req(req),
    .u(u), .v(v), .w(w), .x(x),
    .s(s1), .gnt(g1), .m(m1), .valid(v1)
  );

  mux4_rr_arbiter #(.HOLD(1), .WIDTH(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .req(req),
    .u(u), .v(v), .w(w), .x(x),
    .s(s2), .gnt(g2), .m(m2), .valid(v2)
  );

  int hold[3] = '{2, 4, 1};
  int busy[3];
  int ms[3];
  int mm[3];
  int mv[3];
  int ptr[3];
  int used[3];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  function automatic int winner(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic int data_of(input int i);
    int d[4];
    d[0] = int'(u);
    d[1] = int'(v);
    d[2] = int'(w);
    d[3] = int'(x);
    return d[i];
  endfunction

  task automatic model_step();
    int wn;
    for (int k = 0; k < 3; k++) begin
      if (Reset) begin
        busy[k] = 0; ms[k] = 0; mm[k] = 0;
        mv[k] = 0; ptr[k] = 3; used[k] = 0;
      end else if (busy[k] == 0) begin
        mv[k] = 0;
        wn = winner(req, ptr[k]);
        if (wn >= 0) begin
          busy[k] = 1; ms[k] = wn; used[k] = 1;
        end
      end else begin
        if (req[ms[k]]) begin
          mm[k] = data_of(ms[k]);
          mv[k] = 1;
        end else begin
          mv[k] = 0;
        end
        if (used[k] >= hold[k] || !req[ms[k]]) begin
          ptr[k] = ms[k];
          wn = winner(req, ptr[k]);
          if (wn >= 0) begin
            ms[k] = wn; used[k] = 1;
          end else begin
            busy[k] = 0;
          end
        end else begin
          used[k]++;
        end
      end
    end
  endtask

  task automatic compare();
    logic [1:0] ds;
    logic [3:0] dg;
    logic [1:0] dm;
    logic       dv;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin ds = s0; dg = g0; dm = m0; dv = v0; end
        1: begin ds = s1; dg = g1; dm = m1; dv = v1; end
        default: begin ds = s2; dg = g2; dm = m2; dv = v2; end
      endcase
      check($sformatf("s[h%0d]", hold[k]), 32'(ds), 32'(ms[k]));
      check($sformatf("gnt[h%0d]", hold[k]), 32'(dg),
            busy[k] != 0 ? 32'(1) << ms[k] : 32'd0);
      check($sformatf("m[h%0d]", hold[k]), 32'(dm), 32'(mm[k]));
      check($sformatf("valid[h%0d]", hold[k]), 32'(dv), 32'(mv[k]));
    end
  endtask

  task automatic step();
    @(posedge Clock);
    model_step();
    #1;
    compare();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    req = 4'b1111;
    u = 2'b00; v = 2'b00; w = 2'b00; x = 2'b00;
    step();
    check("reset_gnt", 32'(g0), 32'd0);
    step();
    check("reset_valid", 32'(v0), 32'd0);

    // single requester, back-to-back regrant
    Reset = 1'b0;
    req = 4'b0001;
    u = 2'b01;
    repeat (6) step();
    check("single_gnt", 32'(g0), 32'b0001);
    check("single_m", 32'(m0), 32'b01);

    // full contention
    do_reset();
    u = 2'b01; v = 2'b10; w = 2'b11; x = 2'b00;
    req = 4'b1111;
    repeat (10) step();

    // early release of grantee 1
    do_reset();
    req = 4'b0010;
    step();
    req = 4'b1010;
    step();
    req = 4'b1000;
    step();
    check("early_gnt", 32'(g1), 32'b1000);
    check("early_valid", 32'(v1), 32'd0);
    step();
    step();

    // fairness after idle
    do_reset();
    req = 4'b0100;
    step();
    req = 4'b0000;
    repeat (5) step();
    req = 4'b0101;
    step();
    check("fair_gnt", 32'(g0), 32'b0001);
    step();

    // reset mid-grant
    do_reset();
    req = 4'b1000;
    step();
    step();
    Reset = 1'b1;
    step();
    check("midrst_gnt", 32'(g0), 32'd0);
    Reset = 1'b0;
    req = 4'b1111;
    step();
    check("midrst_first", 32'(g0), 32'b0001);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      Reset = ($urandom_range(0, 49) == 0);
      req = 4'($urandom);
      u = 2'($urandom); v = 2'($urandom);
      w = 2'($urandom); x = 2'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
